// File: rtl/pkt_bufid_refcnt_manager.sv
// Per-bufid reference counter with 9-port round-robin release path and a
// free-bufid FIFO that is pre-filled with every bufid after reset.
module pkt_bufid_refcnt_manager #(
    parameter int BUFID_W = 9,
    parameter int BUF_NUM = 512,
    parameter int CNT_W   = 4,
    parameter int REQ_N   = 9
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [BUFID_W-1:0]         iv_pkt_bufid,
    input  logic                       i_pkt_bufid_wr,
    input  logic [CNT_W-1:0]           iv_pkt_bufid_cnt,
    input  logic [REQ_N*BUFID_W-1:0]   iv_release_bufid,
    input  logic [REQ_N-1:0]           iv_release_wr,
    output logic [REQ_N-1:0]           ov_release_ready,
    output logic [BUFID_W-1:0]         ov_free_bufid,
    output logic                       o_free_bufid_valid,
    input  logic                       i_free_bufid_rd,
    output logic [BUFID_W:0]           ov_free_bufid_num,
    output logic                       o_init_done,
    output logic                       o_err,
    output logic [2:0]                 ov_err_code
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam logic [BUFID_W:0]   NUM_FULL = (BUFID_W+1)'(BUF_NUM);
    localparam logic [BUFID_W:0]   IDX_LAST = (BUFID_W+1)'(BUF_NUM - 1);
    localparam logic [BUFID_W-1:0] PTR_LAST = BUFID_W'(BUF_NUM - 1);
    localparam logic [PTR_W-1:0]   RR_LAST  = PTR_W'(REQ_N - 1);

    logic [0:0]         state_reg;
    logic [BUFID_W:0]   init_idx_reg;
    logic               run;

    logic [CNT_W-1:0]   count_mem [BUF_NUM];
    logic [BUFID_W-1:0] fifo_mem  [BUF_NUM];
    logic [BUFID_W-1:0] rd_ptr_reg;
    logic [BUFID_W-1:0] wr_ptr_reg;
    logic [BUFID_W:0]   num_reg;

    logic               pending_reg    [REQ_N];
    logic [BUFID_W-1:0] pend_bufid_reg [REQ_N];
    logic [REQ_N-1:0]   pending_vec;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;
    logic [BUFID_W-1:0] gnt_bufid;

    logic               s1_valid_reg;
    logic               s1_consumed_reg;
    logic [BUFID_W-1:0] s1_bufid_reg;
    logic [CNT_W-1:0]   s1_cnt_reg;
    logic               s1_act;
    logic               s1_wr_en;
    logic               s1_free;
    logic [CNT_W-1:0]   s1_new_cnt;

    logic               set_run;
    logic               set_do;
    logic [CNT_W-1:0]   set_old;
    logic               collide;

    logic               push_req;
    logic               push_ok;
    logic [BUFID_W-1:0] push_data;
    logic               pop;
    logic               full;

    logic               err1, err2, err3, err4, err5;
    logic               err_reg;
    logic [2:0]         err_code_reg;
    logic [2:0]         err_code_next;

    assign run = (state_reg == ST_RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            init_idx_reg <= init_idx_reg + (BUFID_W+1)'(1);
            if (init_idx_reg == IDX_LAST) begin
                state_reg <= ST_RUN;
            end
        end
    end

    // One-deep pending slot per requester; ready drops while the slot is occupied.
    generate
        for (genvar gi = 0; gi < REQ_N; gi++) begin : g_port
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    pending_reg[gi]    <= 1'b0;
                    pend_bufid_reg[gi] <= '0;
                end else if (gnt_valid && (gnt_idx == PTR_W'(gi))) begin
                    pending_reg[gi] <= 1'b0;
                end else if (iv_release_wr[gi] && ov_release_ready[gi]) begin
                    pending_reg[gi]    <= 1'b1;
                    pend_bufid_reg[gi] <= iv_release_bufid[gi*BUFID_W +: BUFID_W];
                end
            end
            assign pending_vec[gi]      = pending_reg[gi];
            assign ov_release_ready[gi] = run & ~pending_reg[gi];
        end
    endgenerate

    // rr_ptr_reg holds the first port to consider, i.e. one past the last grant.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int j = 0; j < REQ_N; j++) begin
            idx = (int'(rr_ptr_reg) + j) % REQ_N;
            if (!gnt_valid && pending_vec[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    assign gnt_bufid = pend_bufid_reg[gnt_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_reg <= '0;
        end else if (gnt_valid) begin
            rr_ptr_reg <= (gnt_idx == RR_LAST) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    assign set_run = i_pkt_bufid_wr && run;
    assign set_do  = set_run && (iv_pkt_bufid_cnt != '0);
    assign set_old = count_mem[iv_pkt_bufid];
    assign collide = gnt_valid && set_do && (iv_pkt_bufid == gnt_bufid);

    // Count read for the granted bufid; the write of the previous grant lands
    // on this same edge, so forward it to keep back-to-back releases coherent.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_reg    <= 1'b0;
            s1_consumed_reg <= 1'b0;
            s1_bufid_reg    <= '0;
            s1_cnt_reg      <= '0;
        end else begin
            s1_valid_reg    <= gnt_valid;
            s1_consumed_reg <= collide;
            s1_bufid_reg    <= gnt_bufid;
            s1_cnt_reg      <= (s1_wr_en && (s1_bufid_reg == gnt_bufid)) ?
                               s1_new_cnt : count_mem[gnt_bufid];
        end
    end

    assign s1_act     = s1_valid_reg && !s1_consumed_reg;
    assign s1_wr_en   = s1_act && (s1_cnt_reg != '0);
    assign s1_free    = s1_act && (s1_cnt_reg == CNT_W'(1));
    assign s1_new_cnt = s1_cnt_reg - CNT_W'(1);

    // A set issued in the same cycle as a release write to that bufid wins.
    always_ff @(posedge i_clk) begin
        if (state_reg == ST_INIT) begin
            count_mem[init_idx_reg[BUFID_W-1:0]] <= '0;
        end else begin
            if (s1_wr_en) begin
                count_mem[s1_bufid_reg] <= s1_new_cnt;
            end
            if (set_do) begin
                count_mem[iv_pkt_bufid] <= iv_pkt_bufid_cnt;
            end
        end
    end

    assign o_free_bufid_valid = run && (num_reg != '0);
    assign pop       = i_free_bufid_rd && o_free_bufid_valid;
    assign full      = (num_reg == NUM_FULL);
    assign push_req  = (state_reg == ST_INIT) || s1_free;
    assign push_data = (state_reg == ST_INIT) ? init_idx_reg[BUFID_W-1:0] : s1_bufid_reg;
    assign push_ok   = push_req && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            num_reg    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + BUFID_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + BUFID_W'(1);
            end
            if (push_ok && !pop) begin
                num_reg <= num_reg + (BUFID_W+1)'(1);
            end else if (pop && !push_ok) begin
                num_reg <= num_reg - (BUFID_W+1)'(1);
            end
        end
    end

    assign ov_free_bufid     = o_free_bufid_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign ov_free_bufid_num = num_reg;
    assign o_init_done       = run;

    assign err1 = s1_act && (s1_cnt_reg == '0);
    assign err2 = (i_pkt_bufid_wr && !run) || (set_do && (set_old != '0));
    assign err3 = set_run && (iv_pkt_bufid_cnt == '0);
    assign err4 = collide;
    assign err5 = push_req && full && !pop;

    always_comb begin
        err_code_next = 3'd0;
        if (err1) begin
            err_code_next = 3'd1;
        end else if (err2) begin
            err_code_next = 3'd2;
        end else if (err3) begin
            err_code_next = 3'd3;
        end else if (err4) begin
            err_code_next = 3'd4;
        end else if (err5) begin
            err_code_next = 3'd5;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_reg      <= 1'b0;
            err_code_reg <= 3'd0;
        end else begin
            err_reg      <= err1 | err2 | err3 | err4 | err5;
            err_code_reg <= err_code_next;
        end
    end

    assign o_err       = err_reg;
    assign ov_err_code = err_code_reg;

endmodule

// File: tb/tb_pkt_bufid_refcnt_manager.sv
// Scoreboard bench: a count-array / free-queue reference model predicts error
// pulses and FIFO heads; a negedge monitor consumes them as the DUT shows them.
module tb_pkt_bufid_refcnt_manager;

    localparam int BUFID_W = 9;
    localparam int BUF_NUM = 512;
    localparam int CNT_W   = 4;
    localparam int REQ_N   = 9;

    logic                     clk;
    logic                     rst;
    logic [BUFID_W-1:0]       pkt_bufid;
    logic                     pkt_bufid_wr;
    logic [CNT_W-1:0]         pkt_bufid_cnt;
    logic [REQ_N*BUFID_W-1:0] release_bufid;
    logic [REQ_N-1:0]         release_wr;
    logic [REQ_N-1:0]         release_ready;
    logic [BUFID_W-1:0]       free_bufid;
    logic                     free_valid;
    logic                     free_rd;
    logic [BUFID_W:0]         free_num;
    logic                     init_done;
    logic                     err;
    logic [2:0]               err_code;

    pkt_bufid_refcnt_manager #(
        .BUFID_W(BUFID_W), .BUF_NUM(BUF_NUM), .CNT_W(CNT_W), .REQ_N(REQ_N)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .iv_pkt_bufid       (pkt_bufid),
        .i_pkt_bufid_wr     (pkt_bufid_wr),
        .iv_pkt_bufid_cnt   (pkt_bufid_cnt),
        .iv_release_bufid   (release_bufid),
        .iv_release_wr      (release_wr),
        .ov_release_ready   (release_ready),
        .ov_free_bufid      (free_bufid),
        .o_free_bufid_valid (free_valid),
        .i_free_bufid_rd    (free_rd),
        .ov_free_bufid_num  (free_num),
        .o_init_done        (init_done),
        .o_err              (err),
        .ov_err_code        (err_code)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_err_q[$];
    int exp_free_q[$];
    int cnt_m[BUF_NUM];
    int ptr_m;
    int rb[REQ_N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: counts, free queue and round-robin pointer
    task automatic model_reset();
        exp_err_q.delete();
        exp_free_q.delete();
        for (int i = 0; i < BUF_NUM; i++) begin
            cnt_m[i] = 0;
            exp_free_q.push_back(i);
        end
        ptr_m = 0;
    endtask

    task automatic model_push(input int b);
        if (exp_free_q.size() == BUF_NUM) exp_err_q.push_back(5);
        else exp_free_q.push_back(b);
    endtask

    task automatic model_release(input int b);
        if (cnt_m[b] == 0) exp_err_q.push_back(1);
        else if (cnt_m[b] == 1) begin
            cnt_m[b] = 0;
            model_push(b);
        end else cnt_m[b] = cnt_m[b] - 1;
    endtask

    task automatic model_set(input int b, input int c);
        if (c == 0) exp_err_q.push_back(3);
        else begin
            if (cnt_m[b] != 0) exp_err_q.push_back(2);
            cnt_m[b] = c;
        end
    endtask

    // Monitor: consumes expected error codes and free-bufid heads
    always @(negedge clk) begin
        if (!rst) begin
            if (err) begin
                if (exp_err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_unexpected: got code %0d, expected no error", err_code);
                end else begin
                    chk("err_code", int'(err_code), exp_err_q.pop_front());
                end
            end
            if (free_rd) begin
                if (!free_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_valid: got valid 0, expected 1");
                end else if (exp_free_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL free_head: got %0d, expected model queue empty", free_bufid);
                end else begin
                    chk("free_head", int'(free_bufid), exp_free_q.pop_front());
                end
            end
        end
    end

    task automatic check_num(input string name);
        chk(name, int'(free_num), exp_free_q.size());
    endtask

    task automatic do_set(input int b, input int c);
        model_set(b, c);
        $display("set bufid=%0d cnt=%0d", b, c);
        @(posedge clk); #1;
        pkt_bufid     = BUFID_W'(b);
        pkt_bufid_cnt = CNT_W'(c);
        pkt_bufid_wr  = 1'b1;
        @(posedge clk); #1;
        pkt_bufid_wr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_num("num_after_set");
    endtask

    task automatic pop_n(input int n);
        $display("pop %0d", n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            free_rd = 1'b1;
        end
        @(posedge clk); #1;
        free_rd = 1'b0;
    endtask

    // Releases from every port in mask in one cycle, bufids from rb[].
    task automatic release_batch(input logic [REQ_N-1:0] mask);
        int order[$];
        int ret[REQ_N];
        for (int j = 0; j < REQ_N; j++) begin
            int p;
            p = (ptr_m + j) % REQ_N;
            if (mask[p]) order.push_back(p);
        end
        foreach (order[i]) model_release(rb[order[i]]);
        if (order.size() > 0) ptr_m = (order[order.size()-1] + 1) % REQ_N;
        $display("release mask=%03h", mask);
        @(posedge clk); #1;
        chk("ready_idle", int'(release_ready), (1 << REQ_N) - 1);
        for (int p = 0; p < REQ_N; p++) begin
            release_bufid[p*BUFID_W +: BUFID_W] = BUFID_W'(rb[p]);
            ret[p] = 0;
        end
        release_wr = mask;
        @(posedge clk); #1;
        release_wr = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            for (int p = 0; p < REQ_N; p++)
                if (mask[p] && ret[p] == 0 && release_ready[p]) ret[p] = c;
        end
        foreach (order[i]) chk($sformatf("grant_slot_p%0d", order[i]), ret[order[i]], 2 + i);
        @(posedge clk); #1;
        check_num("num_after_release");
    endtask

    task automatic check_outputs_zero();
        chk("rst_ready", int'(release_ready), 0);
        chk("rst_free_bufid", int'(free_bufid), 0);
        chk("rst_valid", int'(free_valid), 0);
        chk("rst_num", int'(free_num), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
    endtask

    task automatic wait_init(input bit set_in_init);
        int done_cycle;
        done_cycle = 0;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            if (set_in_init && c == 10) begin
                exp_err_q.push_back(2);
                pkt_bufid     = BUFID_W'(3);
                pkt_bufid_cnt = CNT_W'(4);
                pkt_bufid_wr  = 1'b1;
            end
            if (c == 11) pkt_bufid_wr = 1'b0;
            if (init_done) begin
                done_cycle = c;
                break;
            end
        end
        chk("init_done_cycle", done_cycle, BUF_NUM);
        check_num("num_after_init");
        chk("head_after_init", int'(free_bufid), 0);
        chk("valid_after_init", int'(free_valid), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        pkt_bufid = '0; pkt_bufid_wr = 1'b0; pkt_bufid_cnt = '0;
        release_bufid = '0; release_wr = '0; free_rd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero();
        rst = 1'b0;
        wait_init(1'b1);

        // pop heads 0..5, then make room in the FIFO
        pop_n(3);
        check_num("num_after_pop3");
        pop_n(3);
        pop_n(30);

        // three releases of bufid 5 in one cycle
        do_set(5, 3);
        rb = '{default: 0};
        rb[0] = 5; rb[3] = 5; rb[8] = 5;
        release_batch(9'b1_0000_1001);

        // second release of a freed bufid is a double free
        do_set(7, 1);
        rb[2] = 7;
        release_batch(9'b0_0000_0100);
        release_batch(9'b0_0000_0100);

        // all ports pending at once
        for (int p = 0; p < REQ_N; p++) begin
            do_set(20 + p, 1);
            rb[p] = 20 + p;
        end
        release_batch(9'h1FF);

        // set collides with the p1 grant of bufid 9
        cnt_m[9] = 2;
        exp_err_q.push_back(4);
        ptr_m = 2;
        $display("collision set bufid=9 cnt=2 with p1 grant");
        @(posedge clk); #1;
        release_bufid[1*BUFID_W +: BUFID_W] = BUFID_W'(9);
        release_wr = 9'b0_0000_0010;
        @(posedge clk); #1;
        release_wr    = '0;
        pkt_bufid     = BUFID_W'(9);
        pkt_bufid_cnt = CNT_W'(2);
        pkt_bufid_wr  = 1'b1;
        @(posedge clk); #1;
        pkt_bufid_wr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_num("num_after_collision");
        rb[4] = 9;
        release_batch(9'b0_0001_0000);
        release_batch(9'b0_0001_0000);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 2);
            if (r == 0) begin
                int n;
                n = $urandom_range(1, 5);
                if (n > exp_free_q.size()) n = exp_free_q.size();
                pop_n(n);
            end else if (r == 1) begin
                do_set($urandom_range(100, 111), $urandom_range(0, 9));
            end else begin
                for (int p = 0; p < REQ_N; p++) rb[p] = $urandom_range(100, 111);
                release_batch(REQ_N'($urandom_range(1, (1 << REQ_N) - 1)));
            end
        end

        // drain the whole FIFO through the monitor
        pop_n(exp_free_q.size());
        repeat (2) @(posedge clk);
        #1;
        chk("valid_when_empty", int'(free_valid), 0);
        check_num("num_when_drained");
        chk("err_queue_drained", exp_err_q.size(), 0);

        // reset in the middle of a multi-port release
        do_set(40, 3);
        @(posedge clk); #1;
        for (int p = 0; p < REQ_N; p++) release_bufid[p*BUFID_W +: BUFID_W] = BUFID_W'(40);
        release_wr = 9'b1_0000_1001;
        @(posedge clk); #1;
        release_wr = '0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_outputs_zero();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init(1'b0);
        pop_n(3);
        repeat (3) @(posedge clk);
        #1;
        check_num("num_final");
        chk("err_queue_final", exp_err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
